// File: rtl/shift_add_multiplier_4.sv
// shift_add_multiplier_4: sequential 4x4 unsigned shift-add multiplier driving an external 4-bit adder
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, a, b     start request with multiplicand/multiplier, captured on acceptance
//   busy, done      busy while iterating, one-cycle done pulse on completion
//   product         last completed 8-bit result, held until next completion
//   add_a, add_b    adder operands: accumulator high nibble, gated multiplicand
//   add_ctrl        adder mode, tied to add
//   add_s           adder result, add_s[4] is the carry-out
module shift_add_multiplier_4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_ctrl,
  input  logic [4:0] add_s
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= 4'd0;
      hi_q      <= 4'd0;
      lo_q      <= 4'd0;
      cnt_q     <= 2'd0;
      product_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  // A step shifts the 9-bit {carry, sum, lo} right by one; add_b is zero when
  // lo[0] is clear, so the adder then just passes hi through.
  always_comb begin
    state_d   = state_q == DONE ? IDLE : state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (state_q == RUN) begin
      {hi_d, lo_d} = {add_s, lo_q[3:1]};
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        product_d = {add_s, lo_q[3:1]};
        state_d   = DONE;
      end
    end else if (start) begin
      mcand_d = a;
      lo_d    = b;
      hi_d    = 4'd0;
      cnt_d   = 2'd0;
      state_d = RUN;
    end
  end
  assign busy     = state_q == RUN;
  assign done     = state_q == DONE;
  assign product  = product_q;
  assign add_a    = hi_q;
  assign add_b    = lo_q[0] ? mcand_q : 4'd0;
  assign add_ctrl = 1'b0;
endmodule

// File: tb/tb_shift_add_multiplier_4.sv
// tb_shift_add_multiplier_4: directed self-checking bench with a behavioural 4-bit adder
module tb_shift_add_multiplier_4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       busy, done, add_ctrl;
  logic [7:0] product;
  logic [3:0] add_a, add_b;
  logic [4:0] add_s;
  int checks = 0;
  int errors = 0;

  shift_add_multiplier_4 dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_ctrl(add_ctrl), .add_s(add_s)
  );

  // Behavioural model of the team adder/subtractor: CTRL=0 adds, CTRL=1 subtracts.
  assign add_s = add_ctrl ? {1'b0, add_a} + {1'b0, ~add_b} + 5'd1
                          : {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (add_ctrl !== 1'b0) begin
      errors++;
      $display("FAIL add_ctrl_monitor got %b want 0 at %0t", add_ctrl, $time);
    end
  end

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, done, product, add_a, add_b} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b product=%h add_a=%h add_b=%h want all 0",
               busy, done, product, add_a, add_b);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_15x15;
    int busy_cnt = 0;
    start = 1'b1; a = 4'hF; b = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy === 1'b1 && done === 1'b0) busy_cnt++;
    end
    @(negedge clk);
    checks++;
    if (busy_cnt != 4) begin
      errors++;
      $display("FAIL 15x15_busy_cycles got %0d want 4", busy_cnt);
    end
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL 15x15_done_latency got done=%b busy=%b want 1 0", done, busy);
    end
    checks++;
    if (product !== 8'hE1) begin
      errors++;
      $display("FAIL 15x15_product got %h want e1", product);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00 || product !== 8'hE1) begin
      errors++;
      $display("FAIL 15x15_after got done=%b busy=%b product=%h want 0 0 e1", done, busy, product);
    end
  endtask

  task automatic test_sweep;
    int bad_timing = 0;
    int bad_prod = 0;
    logic [7:0] exp_p;
    for (int i = 0; i < 256; i++) begin
      start = 1'b1;
      a = 4'(i >> 4);
      b = 4'(i);
      exp_p = 8'((i >> 4) * (i & 15));
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (busy !== 1'b1 || done !== 1'b0) bad_timing++;
      end
      @(negedge clk);
      if (done !== 1'b1 || busy !== 1'b0) bad_timing++;
      if (product !== exp_p) begin
        bad_prod++;
        if (bad_prod < 5) $display("FAIL sweep_product a=%h b=%h got %h want %h", a, b, product, exp_p);
      end
    end
    start = 1'b0;
    checks++;
    if (bad_timing != 0) begin
      errors++;
      $display("FAIL sweep_timing got %0d bad cycles want 0", bad_timing);
    end
    checks++;
    if (bad_prod != 0) begin
      errors++;
      $display("FAIL sweep_products got %0d wrong want 0", bad_prod);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL sweep_idle got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_zero;
    int nz_b = 0;
    start = 1'b1; a = 4'd0; b = 4'd9;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || product !== 8'h00) begin
      errors++;
      $display("FAIL 0x9 got done=%b product=%h want 1 00", done, product);
    end
    @(negedge clk);
    start = 1'b1; a = 4'd9; b = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (add_b !== 4'd0 || busy !== 1'b1) nz_b++;
    end
    checks++;
    if (nz_b != 0) begin
      errors++;
      $display("FAIL 9x0_add_b got %0d bad steps want 0", nz_b);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || product !== 8'h00) begin
      errors++;
      $display("FAIL 9x0 got done=%b product=%h want 1 00", done, product);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_run_start;
    start = 1'b1; a = 4'd13; b = 4'd11;
    @(negedge clk);
    a = 4'd2; b = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || product !== 8'h00) begin
      errors++;
      $display("FAIL mid_run_held got busy=%b product=%h want 1 00", busy, product);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || product !== 8'h8F) begin
      errors++;
      $display("FAIL 13x11 got done=%b product=%h want 1 8f", done, product);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL mid_run_no_restart got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_async_reset;
    int stray_done = 0;
    start = 1'b1; a = 4'd7; b = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, product, add_a, add_b, add_ctrl} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b product=%h add_a=%h add_b=%h ctrl=%b want all 0",
               busy, done, product, add_a, add_b, add_ctrl);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray_done++;
    end
    checks++;
    if (stray_done != 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d bad cycles want 0", stray_done);
    end
    start = 1'b1; a = 4'd3; b = 4'd5;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || product !== 8'h0F) begin
      errors++;
      $display("FAIL 3x5_after_reset got done=%b product=%h want 1 0f", done, product);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_15x15;
    test_sweep;
    test_zero;
    test_mid_run_start;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier_4.md
Name: shift_add_multiplier_4

Overview:
- Sequential 4x4 unsigned multiplier; produces an 8-bit product in 4 iterations.
- Drives the team's combinational 4-bit ripple-carry adder/subtractor (ports A, B, CTRL, 5-bit S) through dedicated add_* ports.
- Consumes the adder's 5-bit result (S[4] = carry when CTRL = 0) and sits directly downstream of and around the adder in the ALU datapath.
- The adder is instantiated beside this block and wired port-to-port; this block contains no adder logic of its own.

Parameters:
- none: operand width is fixed at 4 to match the 4-bit adder.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; sampled on the rising clk edge.
- a  input  4  multiplicand; captured when start is accepted.
- b  input  4  multiplier; captured when start is accepted.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse; product is valid and new.
- product  output  8  last completed result; held until the next completion.
- add_a  output  4  to adder A; equals hi[3:0].
- add_b  output  4  to adder B; equals mcand when lo[0] = 1, else 4'b0000.
- add_ctrl  output  1  to adder CTRL; constant 0 (add only).
- add_s  input  5  from adder S; add_s[4] is the carry-out.

Behaviour:
- Clock/reset: one clock, clk; reset rst is asynchronous and active-high.
- Internal registers:
  - mcand[3:0]
  - hi[3:0], the accumulator upper nibble
  - lo[3:0], the multiplier and lower product bits
  - cnt[1:0]
  - state: IDLE, RUN or DONE
- Reset (asynchronous, any state):
  - state = IDLE.
  - mcand, hi, lo, cnt, product = 0.
  - busy = 0, done = 0.
  - An in-flight operation is discarded and no done pulse is emitted.
- IDLE:
  - busy = 0, done = 0.
  - start = 1 at an edge: mcand <= a, lo <= b, hi <= 0, cnt <= 0, state <= RUN.
- RUN:
  - busy = 1.
  - Each edge performs one step: {hi, lo} <= {add_s[4:0], lo[3:1]}, i.e. a 9-bit {carry, sum} right shift into the 8-bit pair.
  - Because add_b = 0 when lo[0] = 0, add_s = {0, hi} for that step, which is a plain shift.
  - cnt increments each step. The step taken with cnt == 3 also sets product <= next {hi, lo} and state <= DONE.
  - start is ignored while in RUN.
- DONE:
  - done = 1 for exactly this one cycle; busy = 0.
  - start = 1 at the edge: a new operation is accepted exactly as from IDLE (back-to-back allowed).
  - Otherwise state <= IDLE.
- Latency: start accepted at edge t → steps at edges t+1..t+4 → done high and product valid from t+4 to t+5. Throughput is one multiply per 5 cycles.
- Width rules:
  - The carry never exceeds 1 bit, since the maximum hi + mcand is 15 + 15 = 30.
  - product is exact for all 256 operand pairs; no overflow exists.
- add_* outputs are purely combinational from registers, so there is no combinational loop through add_s.
- Boundary cases:
  - a = 0 or b = 0 gives product 0, still 4 cycles.
  - a and b may change after acceptance with no effect.
  - product does not change except on completion or reset.

Test Plan:
- 15 × 15: start with a=4'hF, b=4'hF → done exactly 4 cycles after acceptance; product = 8'hE1 (225); busy high for exactly 4 cycles.
- Sweep all 256 (a, b) pairs, back-to-back with start asserted in DONE → each product = a*b; no idle cycles between operations; exactly one done per operation.
- 13 × 11, with start re-pulsed and a/b changed to 2/2 mid-RUN → product = 8'h8F (143); the mid-RUN start and operands are ignored.
- 0 × 9 then 9 × 0 → product 0 both times; adder stimulus add_b = 0 for every step of the 9 × 0 case.
- Assert rst during cycle 2 of RUN for 7 × 7 → outputs 0 immediately (asynchronously); no done pulse; next start with 3 × 5 → product 8'h0F.
- Monitor adder port add_ctrl → 0 in all cycles, including reset.
